// File: rtl/ip_checksum_check.sv
`default_nettype none
// ============================================================================
//  Module   : ip_checksum_check
//  Purpose  : Receive-side IPv4 header checksum verifier (byte-stream input).
//  Revision : 1.0 - initial release
// ============================================================================
module ip_checksum_check #(
    parameter logic [3:0] IP_VERSION = 4'd4
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        hdr_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        frame_abort,
    output logic        busy,
    output logic        chk_done,
    output logic        chk_ok,
    output logic        hdr_err,
    output logic [15:0] sum_out,
    output logic [5:0]  hdr_len
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FOLD1 = 2'd2,
        S_FOLD2 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [5:0]  byte_cnt_q, byte_cnt_d;
    logic [20:0] acc_q, acc_d;
    logic [16:0] f1_q, f1_d;
    logic [5:0]  hdr_len_q, hdr_len_d;
    logic        chk_done_q, chk_done_d;
    logic        chk_ok_q, chk_ok_d;
    logic        hdr_err_q, hdr_err_d;
    logic [15:0] sum_q, sum_d;

    logic        w_start;
    logic        w_bad_hdr;
    logic [15:0] w_f2;

    assign w_start   = hdr_start & byte_valid;
    assign w_bad_hdr = (byte_data[7:4] != IP_VERSION) || (byte_data[3:0] < 4'd5);
    // Second fold cannot carry again: f1 is at most 0x1001E.
    assign w_f2      = f1_q[15:0] + {15'd0, f1_q[16]};

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= S_IDLE;
            hi_byte_q  <= 8'd0;
            byte_cnt_q <= 6'd0;
            acc_q      <= 21'd0;
            f1_q       <= 17'd0;
            hdr_len_q  <= 6'd0;
            chk_done_q <= 1'b0;
            chk_ok_q   <= 1'b0;
            hdr_err_q  <= 1'b0;
            sum_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            hi_byte_q  <= hi_byte_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            f1_q       <= f1_d;
            hdr_len_q  <= hdr_len_d;
            chk_done_q <= chk_done_d;
            chk_ok_q   <= chk_ok_d;
            hdr_err_q  <= hdr_err_d;
            sum_q      <= sum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_byte_d  = hi_byte_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        f1_d       = f1_q;
        hdr_len_d  = hdr_len_q;
        chk_done_d = 1'b0;
        chk_ok_d   = chk_ok_q;
        hdr_err_d  = hdr_err_q;
        sum_d      = sum_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                // A new header always wins over abort or the header in flight.
                if (w_start) begin
                    if (w_bad_hdr) begin
                        state_d    = S_IDLE;
                        chk_done_d = 1'b1;
                        hdr_err_d  = 1'b1;
                        chk_ok_d   = 1'b0;
                    end else begin
                        state_d    = S_ACCUM;
                        hi_byte_d  = byte_data;
                        hdr_len_d  = {byte_data[3:0], 2'b00};
                        byte_cnt_d = 6'd1;
                        acc_d      = 21'd0;
                    end
                end else if (state_q == S_ACCUM) begin
                    if (frame_abort) begin
                        state_d = S_IDLE;
                    end else if (byte_valid) begin
                        if (byte_cnt_q[0]) begin
                            acc_d = acc_q + {5'd0, hi_byte_q, byte_data};
                        end else begin
                            hi_byte_d = byte_data;
                        end
                        byte_cnt_d = byte_cnt_q + 6'd1;
                        if (byte_cnt_q == hdr_len_q - 6'd1) begin
                            state_d = S_FOLD1;
                        end
                    end
                end
            end
            S_FOLD1: begin
                f1_d    = {12'd0, acc_q[20:16]} + {1'b0, acc_q[15:0]};
                state_d = S_FOLD2;
            end
            S_FOLD2: begin
                chk_done_d = 1'b1;
                sum_d      = w_f2;
                chk_ok_d   = (w_f2 == 16'hFFFF);
                hdr_err_d  = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign chk_done = chk_done_q;
    assign chk_ok   = chk_ok_q;
    assign hdr_err  = hdr_err_q;
    assign sum_out  = sum_q;
    assign hdr_len  = hdr_len_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_checksum_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip_checksum_check
//  Purpose  : Directed + randomized bench with a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ip_checksum_check;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        hdr_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        frame_abort = 1'b0;
    logic        busy, chk_done, chk_ok, hdr_err;
    logic [15:0] sum_out;
    logic [5:0]  hdr_len;

    int n_tests = 0;
    int n_fail  = 0;

    ip_checksum_check #(.IP_VERSION(4'd4)) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .hdr_start   (hdr_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_abort (frame_abort),
        .busy        (busy),
        .chk_done    (chk_done),
        .chk_ok      (chk_ok),
        .hdr_err     (hdr_err),
        .sum_out     (sum_out),
        .hdr_len     (hdr_len)
    );

    always #5 clk = ~clk;

    logic [7:0] hdr1[$] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                            8'hb8, 8'h61, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    logic [7:0] hdr3[$] = '{8'h46, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                            8'hb5, 8'h5f, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7,
                            8'h01, 8'h01, 8'h01, 8'h01};

    // End-around-carry sum over the whole header, folded until no carry remains.
    function automatic logic [15:0] ref_sum(input logic [7:0] q[$]);
        int unsigned s = 0;
        for (int i = 0; i + 1 < q.size(); i += 2) s += {16'd0, q[i], q[i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    // Reference model: header bytes are gathered in a queue and summed at the end.
    bit          m_collect;
    logic [7:0]  m_bytes[$];
    int          m_len;
    int          m_pend;
    logic [15:0] m_pend_sum;
    logic        e_done, e_ok, e_err, e_busy;
    logic [15:0] e_sum;
    logic [5:0]  e_len;

    always @(posedge clk) begin
        if (reset_p) begin
            m_collect = 0; m_bytes.delete(); m_len = 0; m_pend = 0; m_pend_sum = 0;
            e_done = 0; e_ok = 0; e_err = 0; e_sum = 0; e_len = 0;
        end else begin
            e_done = 0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    e_done = 1; e_sum = m_pend_sum; e_ok = (m_pend_sum == 16'hFFFF); e_err = 0;
                end
            end else if (hdr_start && byte_valid) begin
                if (byte_data[7:4] != 4'd4 || byte_data[3:0] < 4'd5) begin
                    m_collect = 0; e_done = 1; e_err = 1; e_ok = 0;
                end else begin
                    m_collect = 1; m_bytes.delete(); m_bytes.push_back(byte_data);
                    m_len = 4 * int'(byte_data[3:0]); e_len = 6'(m_len);
                end
            end else if (m_collect) begin
                if (frame_abort) begin
                    m_collect = 0;
                end else if (byte_valid) begin
                    m_bytes.push_back(byte_data);
                    if (m_bytes.size() == m_len) begin
                        m_pend_sum = ref_sum(m_bytes); m_pend = 2; m_collect = 0;
                    end
                end
            end
        end
        e_busy = m_collect || (m_pend > 0);
        #1;
        n_tests++;
        if ({busy, chk_done, chk_ok, hdr_err, sum_out, hdr_len} !==
            {e_busy, e_done, e_ok, e_err, e_sum, e_len}) begin
            n_fail++;
            $display("FAIL model t=%0t busy/done/ok/err/sum/len got %b%b%b%b %h %0d want %b%b%b%b %h %0d",
                     $time, busy, chk_done, chk_ok, hdr_err, sum_out, hdr_len,
                     e_busy, e_done, e_ok, e_err, e_sum, e_len);
        end
    end

    task automatic drive_byte(input bit st, input logic [7:0] d);
        @(negedge clk);
        hdr_start = st; byte_valid = 1'b1; byte_data = d; frame_abort = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit stall);
        for (int i = 0; i < b.size(); i++) begin
            drive_byte(i == 0, b[i]);
            if (stall && i != b.size() - 1) begin
                @(negedge clk);
                hdr_start = 1'b0; byte_valid = 1'b0;
            end
        end
    endtask

    // Call right after the final byte is driven; the result edge number is checked.
    task automatic wait_done(input string name, input bit chk_sum, input logic [15:0] xsum,
                             input bit xok, input bit xerr, input int xk, input logic [5:0] xlen);
        int  k;
        bit  seen = 0;
        for (k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            hdr_start = 1'b0; byte_valid = 1'b0; frame_abort = 1'b0;
            if (chk_done) begin seen = 1; break; end
        end
        n_tests++;
        if (!seen || k != xk || chk_ok !== xok || hdr_err !== xerr ||
            (chk_sum && (sum_out !== xsum || hdr_len !== xlen)) || (xerr && busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL %s: seen=%0d edge=%0d ok=%b err=%b sum=%h len=%0d busy=%b want edge=%0d ok=%b err=%b sum=%h len=%0d",
                     name, seen, k, chk_ok, hdr_err, sum_out, hdr_len, busy, xk, xok, xerr, xsum, xlen);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] hdr2[$];
        logic [15:0] s;
        int ihl, kind, nb;

        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        check_lit("reset_outputs", {busy, chk_done, chk_ok, hdr_err, sum_out, hdr_len}, 32'd0);
        reset_p = 1'b0;
        @(negedge clk);

        send_bytes(hdr1, 0);
        wait_done("good20", 1, 16'hFFFF, 1, 0, 3, 6'd20);
        repeat (2) @(negedge clk);

        hdr2 = hdr1; hdr2[11] = 8'h62;
        send_bytes(hdr2, 0);
        wait_done("bad_csum", 1, 16'h0001, 0, 0, 3, 6'd20);
        repeat (2) @(negedge clk);

        send_bytes(hdr3, 0);
        wait_done("ihl6", 1, 16'hFFFF, 1, 0, 3, 6'd24);
        repeat (2) @(negedge clk);

        send_bytes(hdr1, 1);
        wait_done("stall_toggle", 1, 16'hFFFF, 1, 0, 3, 6'd20);
        repeat (2) @(negedge clk);

        drive_byte(1, 8'h65);
        wait_done("bad_version", 0, 16'h0, 0, 1, 1, 6'd0);
        @(negedge clk);
        drive_byte(1, 8'h44);
        wait_done("bad_ihl", 0, 16'h0, 0, 1, 1, 6'd0);
        repeat (2) @(negedge clk);

        send_bytes(hdr1[0:9], 0);
        @(negedge clk);
        hdr_start = 1'b0; byte_valid = 1'b0; frame_abort = 1'b1;
        @(posedge clk); #1;
        frame_abort = 1'b0;
        check_lit("abort_busy_done", {30'd0, busy, chk_done}, 32'd0);
        repeat (4) @(negedge clk);
        send_bytes(hdr1, 0);
        wait_done("after_abort", 1, 16'hFFFF, 1, 0, 3, 6'd20);
        repeat (2) @(negedge clk);

        send_bytes(hdr2[0:7], 0);
        send_bytes(hdr1, 0);
        wait_done("restart", 1, 16'hFFFF, 1, 0, 3, 6'd20);
        repeat (2) @(negedge clk);

        send_bytes(hdr1[0:5], 0);
        @(negedge clk);
        hdr_start = 1'b0; byte_valid = 1'b0; reset_p = 1'b1;
        #1;
        check_lit("reset_mid_accum", {busy, chk_done, chk_ok, hdr_err, sum_out, hdr_len}, 32'd0);
        @(negedge clk);
        reset_p = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized frames; the per-cycle model compare does the checking.
        repeat (80) begin
            kind = $urandom_range(0, 9);
            ihl  = $urandom_range(5, 15);
            q.delete();
            q.push_back({4'h4, 4'(ihl)});
            for (int i = 1; i < ihl * 4; i++) q.push_back(8'($urandom));
            q[10] = 8'h00; q[11] = 8'h00;
            s = ~ref_sum(q);
            q[10] = s[15:8]; q[11] = s[7:0];
            if (kind == 0) q[0] = {4'(4 + $urandom_range(1, 11)), 4'(ihl)};
            if (kind == 1) q[0] = {4'h4, 4'($urandom_range(0, 4))};
            if (kind == 2) begin
                nb = $urandom_range(1, ihl * 4 - 1);
                q[nb] = q[nb] ^ 8'($urandom_range(1, 255));
            end
            nb = (kind == 3) ? $urandom_range(1, ihl * 4 - 2) : ihl * 4;
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    hdr_start = 1'($urandom_range(0, 1)); byte_valid = 1'b0;
                    byte_data = 8'($urandom); frame_abort = 1'b0;
                end
                if (i > 0 && $urandom_range(0, 59) == 0) begin
                    @(negedge clk);
                    hdr_start = 1'b0; byte_valid = 1'($urandom_range(0, 1));
                    byte_data = 8'($urandom); frame_abort = 1'b1;
                    break;
                end
                drive_byte(i == 0, q[i]);
            end
            if (kind != 3) begin
                repeat ($urandom_range(3, 6)) begin
                    @(negedge clk);
                    hdr_start = 1'b0; byte_valid = 1'($urandom_range(0, 1));
                    byte_data = 8'($urandom); frame_abort = ($urandom_range(0, 5) == 0);
                end
            end
        end

        @(negedge clk);
        hdr_start = 1'b0; byte_valid = 1'b0; frame_abort = 1'b0;
        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ip_checksum_check.md
Name: ip_checksum_check

Overview:
- Receive-side IPv4 header checksum verifier for the GMII UDP stack; the counterpart of the transmit-side checksum generator.
- Consumes the received IP header as a byte stream from the RX parser, starting at the version/IHL byte.
- Accumulates the 16-bit one's-complement sum over the IHL*4 header bytes, including the checksum field, and folds it.
- Reports pass when the folded sum equals 0xFFFF. Also flags malformed version/IHL.

Parameters:
- IP_VERSION, 4, required value of the version nibble; any other value sets hdr_err.

Ports:
- clk  in  1  system clock (GMII RX clock domain)
- reset_p  in  1  reset, asynchronous, active-high
- hdr_start  in  1  marks the first IP header byte; only valid when byte_valid=1
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  header byte, network order
- frame_abort  in  1  discards the header currently being accumulated
- busy  out  1  high in any state other than IDLE
- chk_done  out  1  one-cycle pulse when a result is available
- chk_ok  out  1  header checksum correct; held until the next chk_done
- hdr_err  out  1  version or IHL invalid; held until the next chk_done
- sum_out  out  16  folded one's-complement sum (0xFFFF = good); held until the next chk_done
- hdr_len  out  6  header length in bytes (IHL*4), captured on hdr_start

Behaviour:
- Reset: state=IDLE; all outputs, the accumulator and the counters are 0.
- States: IDLE, ACCUM, FOLD1, FOLD2.

hdr_start byte (hdr_start & byte_valid), taken in IDLE or ACCUM:
- If byte_data[7:4]!=IP_VERSION or byte_data[3:0]<5: go to IDLE. Next cycle chk_done=1, hdr_err=1, chk_ok=0, sum_out unchanged.
- Otherwise: go to ACCUM with hi_byte<=byte_data, hdr_len<=byte_data[3:0]*4, byte_cnt<=1, acc(21 bits)<=0.

ACCUM, on each byte_valid:
- Odd byte_cnt: acc<=acc+{hi_byte,byte_data}.
- Even byte_cnt: hi_byte<=byte_data.
- byte_cnt increments.
- Cycles with byte_valid=0 are stalls; all state is held.
- Last byte (byte_cnt==hdr_len-1, always odd): add the word, then go to FOLD1.

Folding and result:
- FOLD1: f1(17 bits)<=acc[20:16]+acc[15:0]; go to FOLD2.
- FOLD2: f2<=f1[16]+f1[15:0]; registered in the same edge: chk_done<=1, sum_out<=f2, chk_ok<=(f2==16'hFFFF), hdr_err<=0; go to IDLE.

Latency:
- The last header byte is accepted at the edge ending cycle N.
- chk_done is high during cycle N+3.

Accumulator width:
- 30 words * 0xFFFF < 2^21, so 21 bits never overflow.
- Two folds always yield a 16-bit result.

Boundary conditions:
- hdr_start&byte_valid during ACCUM: the current header is discarded with no chk_done; a new header starts from this byte.
- frame_abort in ACCUM: go to IDLE with no chk_done; held outputs are unchanged. frame_abort in IDLE, FOLD1 or FOLD2 is ignored, so a started fold completes.
- hdr_start or byte_valid in FOLD1/FOLD2: ignored. Upstream guarantees the inter-frame gap.
- byte_valid without hdr_start in IDLE: ignored.
- hdr_start with byte_valid=0: ignored.
- Reset mid-operation: immediate return to the reset values; no chk_done.
- frame_abort and hdr_start&byte_valid in the same cycle in ACCUM: hdr_start wins and a restart occurs.

Test Plan:
1. Good 20-byte header, one byte per cycle: 45 00 00 73 00 00 40 00 40 11 b8 61 c0 a8 00 01 c0 a8 00 c7 -> hdr_len=20; chk_done 3 cycles after the last byte; sum_out=FFFF, chk_ok=1, hdr_err=0.
2. Same header with the checksum changed to b8 62 -> sum_out=0x0001, chk_ok=0, hdr_err=0.
3. IHL=6 header: 46 00 00 73 00 00 40 00 40 11 b5 5f c0 a8 00 01 c0 a8 00 c7 01 01 01 01 -> hdr_len=24, sum_out=FFFF, chk_ok=1. Repeat case 1 with byte_valid toggling every other cycle -> identical result, chk_done 3 cycles after the last valid byte.
4. First byte 0x65 (version 6), then first byte 0x44 (IHL=4) -> each gives chk_done the following cycle with hdr_err=1 and chk_ok=0; busy stays 0.
5. frame_abort after 10 bytes of the case 1 header -> no chk_done, busy drops next cycle. The case 1 header sent afterwards -> chk_ok=1.
6. hdr_start reasserted at byte 8 of a corrupted header, followed by the full case 1 header -> exactly one chk_done, chk_ok=1. Also assert reset_p mid-ACCUM -> all outputs 0, no chk_done.
